bubble_host_sequencer: RTL and testbench

- Host-side counterpart of the bubble drive emulator: generates the bubble controller strobes nBSEN, nREPEN and nBOOTEN that the emulator consumes.
- Samples the emulator's two-loop serial data (DOUT0/DOUT1) and packs it into bytes.
- Used as a synthesizable stimulus/host in system benches, and in the bring-up board that replaces the original controller timing with programmable cycle counts.

---
 rtl/bubble_host_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_bubble_host_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bubble_host_sequencer.sv
// bubble_host_sequencer
//   Host-side sequencer for a bubble drive emulator. Generates the nBSEN,
//   nREPEN and nBOOTEN controller strobes with programmable cycle counts and
//   packs the two-loop serial data (DOUT1/DOUT0) into bytes, MSB pair first.
//
//   Optional build macro: BUBBLE_HOST_LOOPSWAP_EN adds input swap_en
//   (sampled at command accept) which reverses the loop order of each pair.
//
// Ports
//   MCLK, MRST             clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake: a command is accepted in a cycle
//                          where both are high; cmd_ready is high only in IDLE,
//                          and cmd_valid while busy is ignored (not queued)
//   cmd_boot, cmd_seek     command type (1 = boot) and page-mode seek cycles
//   DOUT0, DOUT1           bubble data from loops 0 and 1 (asynchronous)
//   nBSEN/nREPEN/nBOOTEN   active-low controller strobes (registered)
//   byte_data, byte_valid  assembled byte and its one-cycle strobe
//   busy, done             not-IDLE flag and one-cycle return-to-IDLE pulse
module bubble_host_sequencer #(
  parameter int unsigned REP_DELAY     = 2500,
  parameter int unsigned REP_LOW       = 34,
  parameter int unsigned REP_PERIOD    = 96,
  parameter int unsigned BOOT_PULSES   = 8,
  parameter int unsigned BOOT_TAIL     = 21,
  parameter int unsigned BIT_PERIOD    = 96,
  parameter int unsigned DATA_DELAY    = 200,
  parameter int unsigned PAGE_BITTIMES = 256
) (
  input  logic        MCLK,
  input  logic        MRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_boot,
  input  logic [23:0] cmd_seek,
`ifdef BUBBLE_HOST_LOOPSWAP_EN
  input  logic        swap_en,
`endif
  input  logic        DOUT0,
  input  logic        DOUT1,
  output logic        nBSEN,
  output logic        nREPEN,
  output logic        nBOOTEN,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, BOOT_WAIT, BOOT_PULSE, BOOT_TAIL_S, PAGE_WAIT,
    PAGE_SEEK, PAGE_PULSE, PAGE_CAPTURE, FINISH
  } state_t;

  localparam logic [23:0] DELAY_M1  = 24'(REP_DELAY - 1);
  localparam logic [23:0] LOW_M1    = 24'(REP_LOW - 1);
  localparam logic [23:0] PERIOD_M1 = 24'(REP_PERIOD - 1);
  localparam logic [23:0] PULSES_M1 = 24'(BOOT_PULSES - 1);
  localparam logic [23:0] TAIL_M1   = 24'(BOOT_TAIL - 1);
  localparam logic [23:0] BIT_M1    = 24'(BIT_PERIOD - 1);
  localparam logic [23:0] DDELAY    = 24'(DATA_DELAY);
  localparam logic [23:0] NSAMPLES  = 24'(PAGE_BITTIMES);

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;         // cycles spent in the current phase
  logic [23:0] pulses, pulses_n;   // boot pulses completed
  logic [23:0] scnt, scnt_n;       // cycles until the next sample point
  logic [23:0] ksamp, ksamp_n;     // samples taken this page
  logic [5:0]  shreg, shreg_n;     // first three pairs of the byte in progress
  logic [23:0] seek_q, seek_q_n;
  logic        nbsen_n, nrepen_n, nbooten_n, byte_valid_n, done_n;
  logic [7:0]  byte_data_n;
  logic [1:0]  sync0, sync1;       // 2-flop synchronizers, [1] is the output
  logic [1:0]  smp;
`ifdef BUBBLE_HOST_LOOPSWAP_EN
  logic        swap_q, swap_q_n;
  assign smp = swap_q ? {sync0[1], sync1[1]} : {sync1[1], sync0[1]};
`else
  assign smp = {sync1[1], sync0[1]};
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge MCLK or posedge MRST) begin
    if (MRST) begin
      state      <= IDLE;
      cnt        <= '0;
      pulses     <= '0;
      scnt       <= '0;
      ksamp      <= '0;
      shreg      <= '0;
      seek_q     <= '0;
      nBSEN      <= 1'b1;
      nREPEN     <= 1'b1;
      nBOOTEN    <= 1'b1;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      done       <= 1'b0;
      sync0      <= '0;
      sync1      <= '0;
`ifdef BUBBLE_HOST_LOOPSWAP_EN
      swap_q     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pulses     <= pulses_n;
      scnt       <= scnt_n;
      ksamp      <= ksamp_n;
      shreg      <= shreg_n;
      seek_q     <= seek_q_n;
      nBSEN      <= nbsen_n;
      nREPEN     <= nrepen_n;
      nBOOTEN    <= nbooten_n;
      byte_data  <= byte_data_n;
      byte_valid <= byte_valid_n;
      done       <= done_n;
      sync0      <= {sync0[0], DOUT0};
      sync1      <= {sync1[0], DOUT1};
`ifdef BUBBLE_HOST_LOOPSWAP_EN
      swap_q     <= swap_q_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pulses_n     = pulses;
    scnt_n       = scnt;
    ksamp_n      = ksamp;
    shreg_n      = shreg;
    seek_q_n     = seek_q;
    nbsen_n      = nBSEN;
    nrepen_n     = nREPEN;
    nbooten_n    = nBOOTEN;
    byte_data_n  = byte_data;
    byte_valid_n = 1'b0;
    done_n       = 1'b0;
`ifdef BUBBLE_HOST_LOOPSWAP_EN
    swap_q_n     = swap_q;
`endif

    // The capture timer runs from the nREPEN falling edge regardless of
    // whether the pulse is still low, so short DATA_DELAY overlaps the pulse.
    if ((state == PAGE_PULSE || state == PAGE_CAPTURE) && ksamp != NSAMPLES) begin
      if (scnt == '0) begin
        shreg_n = {shreg[3:0], smp};
        ksamp_n = ksamp + 24'd1;
        scnt_n  = BIT_M1;
        if (ksamp[1:0] == 2'd3) begin
          byte_data_n  = {shreg, smp};
          byte_valid_n = 1'b1;
        end
      end else begin
        scnt_n = scnt - 24'd1;
      end
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          seek_q_n = cmd_seek;
`ifdef BUBBLE_HOST_LOOPSWAP_EN
          swap_q_n = swap_en;
`endif
          cnt_n    = '0;
          nbsen_n  = 1'b0;
          if (cmd_boot) begin
            nbooten_n = 1'b0;
            state_n   = BOOT_WAIT;
          end else begin
            state_n   = PAGE_WAIT;
          end
        end
      end
      BOOT_WAIT: begin
        if (cnt == DELAY_M1) begin
          state_n  = BOOT_PULSE;
          cnt_n    = '0;
          pulses_n = '0;
          nrepen_n = 1'b0;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      BOOT_PULSE: begin
        // cnt is the position inside the current REP_PERIOD window.
        if (pulses == PULSES_M1 && cnt == LOW_M1) begin
          state_n  = BOOT_TAIL_S;
          cnt_n    = '0;
          nrepen_n = 1'b1;
        end else if (cnt == PERIOD_M1) begin
          cnt_n    = '0;
          pulses_n = pulses + 24'd1;
          nrepen_n = 1'b0;
        end else begin
          cnt_n = cnt + 24'd1;
          if (cnt == LOW_M1) nrepen_n = 1'b1;
        end
      end
      BOOT_TAIL_S: begin
        if (cnt == TAIL_M1) begin
          state_n   = FINISH;
          nbsen_n   = 1'b1;
          nbooten_n = 1'b1;
          done_n    = 1'b1;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      PAGE_WAIT, PAGE_SEEK: begin
        if ((state == PAGE_WAIT && cnt == DELAY_M1 && seek_q != '0)) begin
          state_n = PAGE_SEEK;
          cnt_n   = '0;
        end else if ((state == PAGE_WAIT && cnt == DELAY_M1) ||
                     (state == PAGE_SEEK && cnt == seek_q - 24'd1)) begin
          state_n  = PAGE_PULSE;
          cnt_n    = '0;
          nrepen_n = 1'b0;
          scnt_n   = DDELAY;
          ksamp_n  = '0;
          shreg_n  = '0;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      PAGE_PULSE: begin
        if (cnt == LOW_M1) begin
          state_n  = PAGE_CAPTURE;
          nrepen_n = 1'b1;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      PAGE_CAPTURE: begin
        // All samples taken: the final byte_valid is on the outputs now.
        if (ksamp == NSAMPLES) begin
          state_n = FINISH;
          nbsen_n = 1'b1;
          done_n  = 1'b1;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bubble_host_sequencer.sv
module tb_bubble_host_sequencer;

  localparam int DD = 8;
  localparam int BP = 12;

  logic        MCLK = 1'b0;
  logic        MRST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_boot = 1'b0;
  logic [23:0] cmd_seek = '0;
  logic        swap_en = 1'b0;
  logic        DOUT0 = 1'b0;
  logic        DOUT1 = 1'b0;
  logic        cmd_ready, nBSEN, nREPEN, nBOOTEN, byte_valid, busy, done;
  logic [7:0]  byte_data;

  bubble_host_sequencer #(
    .REP_DELAY(10), .REP_LOW(5), .REP_PERIOD(20), .BOOT_PULSES(3),
    .BOOT_TAIL(4), .BIT_PERIOD(BP), .DATA_DELAY(DD), .PAGE_BITTIMES(8)
  ) dut (
    .MCLK(MCLK), .MRST(MRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_boot(cmd_boot), .cmd_seek(cmd_seek),
`ifdef BUBBLE_HOST_LOOPSWAP_EN
    .swap_en(swap_en),
`endif
    .DOUT0(DOUT0), .DOUT1(DOUT1), .nBSEN(nBSEN), .nREPEN(nREPEN),
    .nBOOTEN(nBOOTEN), .byte_data(byte_data), .byte_valid(byte_valid),
    .busy(busy), .done(done)
  );

  // clock / cycle index
  always #5 MCLK = ~MCLK;
  int cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  int n_checks = 0, n_pass = 0, n_fail = 0;
  int rep_fall_q[$], rep_rise_q[$], bsen_fall_q[$], bsen_rise_q[$];
  int booten_fall_q[$], booten_rise_q[$], bv_q[$];
  int done_cnt = 0, done_cyc = -1;
  logic [1:0] pat [8] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Monitor + emulated drive data. The drive presents each bit only in the
  // single pin cycle that reaches the sample point two synchronizer stages
  // later; every other cycle carries random data.
  logic prev_rep = 1'b1, prev_bsen = 1'b1, prev_boot = 1'b1;
  int fall_cyc = -1;
  always @(negedge MCLK) begin
    int rel;
    if (prev_rep && !nREPEN) begin rep_fall_q.push_back(cyc); fall_cyc = cyc; end
    if (!prev_rep && nREPEN) rep_rise_q.push_back(cyc);
    if (prev_bsen && !nBSEN) bsen_fall_q.push_back(cyc);
    if (!prev_bsen && nBSEN) bsen_rise_q.push_back(cyc);
    if (prev_boot && !nBOOTEN) booten_fall_q.push_back(cyc);
    if (!prev_boot && nBOOTEN) booten_rise_q.push_back(cyc);
    prev_rep = nREPEN; prev_bsen = nBSEN; prev_boot = nBOOTEN;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (byte_valid) begin
      bv_q.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_byte", 32'(byte_data), 32'hFFFF_FFFF);
      else chk("byte", 32'(byte_data), 32'(exp_q.pop_front()));
    end
    rel = cyc + 2 - fall_cyc - DD;
    if (fall_cyc >= 0 && rel >= 0 && rel % BP == 0 && rel / BP < 8)
      {DOUT1, DOUT0} = pat[rel / BP];
    else
      {DOUT1, DOUT0} = 2'($urandom_range(0, 3));
  end

  // driver tasks
  task automatic clear_logs();
    rep_fall_q.delete(); rep_rise_q.delete(); bsen_fall_q.delete();
    bsen_rise_q.delete(); booten_fall_q.delete(); booten_rise_q.delete();
    bv_q.delete(); done_cnt = 0; done_cyc = -1;
  endtask

  task automatic send_cmd(input logic boot, input int seek, input logic swp, output int acc);
    chk("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_boot = boot; cmd_seek = 24'(seek); swap_en = swp;
    cmd_valid = 1'b1;
    acc = cyc;
    @(negedge MCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin @(negedge MCLK); k++; end
    chk("done_seen", 32'(done_cnt > 0), 1);
    repeat (2) @(negedge MCLK);
    chk("done_once", 32'(done_cnt), 1);
    chk("ready_after", 32'({cmd_ready, busy}), 32'b10);
  endtask

  task automatic page_run(input int seek, input logic swp, output int fall);
    int a;
    clear_logs();
    send_cmd(1'b0, seek, swp, a);
    wait_done(3000);
    fall = qget(rep_fall_q, 0);
    chk("page_fall", 32'(fall), 32'(a + 11 + seek));
    chk("page_rep_rise", 32'(qget(rep_rise_q, 0)), 32'(fall + 5));
    chk("page_bv0", 32'(qget(bv_q, 0)), 32'(fall + DD + 3 * BP + 1));
    chk("page_bv1", 32'(qget(bv_q, 1)), 32'(fall + DD + 7 * BP + 1));
    chk("page_bsen_fall", 32'(qget(bsen_fall_q, 0)), 32'(a + 1));
    chk("page_bsen_rise", 32'(qget(bsen_rise_q, 0)), 32'(fall + DD + 7 * BP + 2));
    chk("page_no_booten", 32'(booten_fall_q.size()), 0);
    chk("page_done_cyc", 32'(done_cyc), 32'(fall + DD + 7 * BP + 2));
    chk("page_queue_empty", 32'(exp_q.size()), 0);
    fall = fall - a;
  endtask

  initial begin
    int a, f0, f1, k;
    // reset
    repeat (3) @(negedge MCLK);
    chk("reset_strobes", 32'({nBSEN, nREPEN, nBOOTEN}), 32'b111);
    chk("reset_flags", 32'({cmd_ready, busy, done, byte_valid}), 32'b1000);
    chk("reset_byte", 32'(byte_data), 0);
    MRST = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge MCLK);
      chk("idle", 32'({nBSEN, nREPEN, nBOOTEN, cmd_ready, busy, byte_valid, done}), 32'b1111000);
    end

    // boot sequence, with a command attempt while busy that must be ignored
    clear_logs();
    send_cmd(1'b1, 0, 1'b0, a);
    repeat (3) @(negedge MCLK);
    chk("busy_during_boot", 32'({busy, cmd_ready}), 32'b10);
    cmd_boot = 1'b0; cmd_valid = 1'b1;
    @(negedge MCLK);
    cmd_valid = 1'b0;
    wait_done(3000);
    chk("boot_bsen_fall", 32'(qget(bsen_fall_q, 0)), 32'(a + 1));
    chk("boot_booten_fall", 32'(qget(booten_fall_q, 0)), 32'(a + 1));
    chk("boot_pulse_count", 32'(rep_fall_q.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk("boot_rep_fall", 32'(qget(rep_fall_q, i)), 32'(a + 11 + 20 * i));
      chk("boot_rep_rise", 32'(qget(rep_rise_q, i)), 32'(a + 16 + 20 * i));
    end
    chk("boot_bsen_rise", 32'(qget(bsen_rise_q, 0)), 32'(a + 60));
    chk("boot_booten_rise", 32'(qget(booten_rise_q, 0)), 32'(a + 60));
    chk("boot_done_cyc", 32'(done_cyc), 32'(a + 60));
    chk("boot_no_bytes", 32'(bv_q.size()), 0);

    // page read, no seek, then with seek 1000
    exp_q.push_back(8'hC9); exp_q.push_back(8'h63);
    page_run(0, 1'b0, f0);
    exp_q.push_back(8'hC9); exp_q.push_back(8'h63);
    page_run(1000, 1'b0, f1);
    chk("seek_delta", 32'(f1 - f0), 1000);

    // reset in the middle of capture, after six samples
    clear_logs();
    exp_q.push_back(8'hC9);
    send_cmd(1'b0, 0, 1'b0, a);
    k = 0;
    while (rep_fall_q.size() == 0 && k < 100) begin @(negedge MCLK); k++; end
    chk("mrst_fall_seen", 32'(rep_fall_q.size()), 1);
    f0 = qget(rep_fall_q, 0);
    while (cyc < f0 + DD + 5 * BP + 2 && k < 300) begin @(negedge MCLK); k++; end
    MRST = 1'b1;
    #1;
    chk("mrst_strobes", 32'({nBSEN, nREPEN, nBOOTEN}), 32'b111);
    chk("mrst_flags", 32'({cmd_ready, busy, done, byte_valid}), 32'b1000);
    chk("mrst_byte", 32'(byte_data), 0);
    @(negedge MCLK);
    MRST = 1'b0;
    repeat (60) @(negedge MCLK);
    chk("mrst_bytes", 32'(bv_q.size()), 1);
    chk("mrst_queue_empty", 32'(exp_q.size()), 0);
    exp_q.push_back(8'hC9); exp_q.push_back(8'h63);
    page_run(0, 1'b0, f1);

`ifdef BUBBLE_HOST_LOOPSWAP_EN
    exp_q.push_back(8'hC6); exp_q.push_back(8'h93);
    page_run(0, 1'b1, f1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
